// File: rtl/op2_imm_encoder_if.sv
// Request/result handshake bundle for the operand-2 immediate encoder.
// The requester (master) drives the request and out_ready; the encoder (slave) drives the rest.
interface op2_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_found;
  logic [3:0]  out_rotate;
  logic [7:0]  out_imm8;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_found, out_rotate, out_imm8
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_found, out_rotate, out_imm8
  );
endinterface

// File: rtl/op2_imm_encoder.sv
// Iterative ARM rotated-immediate encoder: tries one even rotation per cycle, lowest first,
// and reports the first (rotate, imm8) whose imm8 ROR 2*rotate reproduces the constant.
module op2_imm_encoder (
  input  logic               clk,
  input  logic               rst_n,
  op2_imm_encoder_if.slave   bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]  state_q;
  logic [31:0] value_q;
  logic [3:0]  rot_q;
  logic        found_q;
  logic [3:0]  rotate_q;
  logic [7:0]  imm8_q;

  logic [4:0]  shamt;
  logic [31:0] cand;
  logic        match;

  // Undo the decoder's ROR by rotating left; a shift by 32 yields zero, so shamt=0 is safe.
  assign shamt = {rot_q, 1'b0};
  assign cand  = (value_q << shamt) | (value_q >> (6'd32 - {1'b0, shamt}));
  assign match = (cand[31:8] == 24'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      value_q  <= '0;
      rot_q    <= '0;
      found_q  <= 1'b0;
      rotate_q <= '0;
      imm8_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            value_q <= bus.in_value;
            rot_q   <= '0;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (match) begin
            found_q  <= 1'b1;
            rotate_q <= rot_q;
            imm8_q   <= cand[7:0];
            state_q  <= DONE;
          end else if (rot_q == 4'd15) begin
            found_q  <= 1'b0;
            rotate_q <= '0;
            imm8_q   <= '0;
            state_q  <= DONE;
          end else begin
            rot_q <= rot_q + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state register, so nothing from in_* reaches out_*.
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_found  = found_q;
  assign bus.out_rotate = rotate_q;
  assign bus.out_imm8   = imm8_q;

endmodule

// File: tb/tb_op2_imm_encoder.sv
// Self-checking bench for op2_imm_encoder: directed plan cases, backpressure, mid-search reset,
// back-to-back and randomized requests scored against a brute-force decode-side reference.
module tb_op2_imm_encoder;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  op2_imm_encoder_if bus ();

  op2_imm_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    logic [63:0] d;
    d = {x, x} >> s;
    return d[31:0];
  endfunction

  // Reference: search the decoder's whole output space, lowest rotate first.
  function automatic void ref_encode(input logic [31:0] v, output logic f,
                                     output logic [3:0] r, output logic [7:0] i);
    f = 1'b0; r = '0; i = '0;
    for (int rr = 0; rr < 16; rr++) begin
      for (int ii = 0; ii < 256; ii++) begin
        if (!f && ror32({24'd0, ii[7:0]}, 2 * rr) == v) begin
          f = 1'b1; r = rr[3:0]; i = ii[7:0];
        end
      end
    end
  endfunction

  // Issue one request, wait (bounded) for the result, hold it for 'hold' cycles, then accept it.
  task automatic do_request(input logic [31:0] v, input int hold, output int lat,
                            output logic f, output logic [3:0] r, output logic [7:0] i,
                            output logic busy_ok, output logic stable_ok, output logic hs_ok);
    lat = -1; f = 1'b0; r = '0; i = '0; busy_ok = 1'b1; stable_ok = 1'b1; hs_ok = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_value  = v;
    if (bus.in_ready !== 1'b1) busy_ok = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) busy_ok = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) lat = c;
      else if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
    end
    if (lat < 0) return;
    f = bus.out_found; r = bus.out_rotate; i = bus.out_imm8;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.out_found, bus.out_rotate, bus.out_imm8} !== {f, r, i}) stable_ok = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    hs_ok = (bus.out_valid === 1'b0 && bus.in_ready === 1'b1);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_value = '0; bus.out_ready = 1'b0;
    #12;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_found, bus.out_rotate, bus.out_imm8} !== 15'h4000) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b found=%0b rot=%0d imm=%h, want rdy=1 vld=0 found=0 rot=0 imm=00",
               bus.in_ready, bus.out_valid, bus.out_found, bus.out_rotate, bus.out_imm8);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] vals [5] = '{32'h000000FF, 32'hFF000000, 32'hF000000F, 32'h00000104, 32'h00000102};
    logic        efs  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  ers  [5] = '{4'd0, 4'd4, 4'd2, 4'd15, 4'd0};
    logic [7:0]  eis  [5] = '{8'hFF, 8'hFF, 8'hFF, 8'h41, 8'h00};
    int          els  [5] = '{1, 5, 3, 16, 16};
    int lat; logic f, b_ok, s_ok, h_ok; logic [3:0] r; logic [7:0] i;
    for (int n = 0; n < 5; n++) begin
      do_request(vals[n], 0, lat, f, r, i, b_ok, s_ok, h_ok);
      checks++;
      if ({f, r, i} !== {efs[n], ers[n], eis[n]}) begin
        errors++;
        $display("FAIL directed_result %h: got found=%0b rot=%0d imm=%h, want found=%0b rot=%0d imm=%h",
                 vals[n], f, r, i, efs[n], ers[n], eis[n]);
      end
      checks++;
      if (lat !== els[n]) begin
        errors++;
        $display("FAIL directed_latency %h: got %0d, want %0d", vals[n], lat, els[n]);
      end
      checks++;
      if (!(b_ok && h_ok)) begin
        errors++;
        $display("FAIL directed_handshake %h: got busy_ok=%0b hs_ok=%0b, want 1/1", vals[n], b_ok, h_ok);
      end
    end
  endtask

  task automatic test_backpressure();
    logic ok = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_value = 32'h0;
    @(posedge clk); #1;
    bus.in_value = 32'h12;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_found, bus.out_rotate, bus.out_imm8} !== 14'h3000) begin
      errors++;
      $display("FAIL bp_zero_result: got vld=%0b found=%0b rot=%0d imm=%h, want vld=1 found=1 rot=0 imm=00",
               bus.out_valid, bus.out_found, bus.out_rotate, bus.out_imm8);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_found !== 1'b1 ||
          bus.out_rotate !== 4'd0 || bus.out_imm8 !== 8'h00) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_hold: got outputs or in_ready changing under backpressure, want stable found=1 rot=0 imm=00 rdy=0");
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%0b vld=%0b, want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_found, bus.out_rotate, bus.out_imm8} !== 14'h3012) begin
      errors++;
      $display("FAIL bp_next_request: got vld=%0b found=%0b rot=%0d imm=%h, want vld=1 found=1 rot=0 imm=12",
               bus.out_valid, bus.out_found, bus.out_rotate, bus.out_imm8);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic f, b_ok, s_ok, h_ok; logic [3:0] r; logic [7:0] i;
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_value = 32'h102;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_found, bus.out_rotate, bus.out_imm8} !== 15'h4000) begin
      errors++;
      $display("FAIL reset_mid_outputs: got rdy=%0b vld=%0b found=%0b rot=%0d imm=%h, want rdy=1 vld=0 found=0 rot=0 imm=00",
               bus.in_ready, bus.out_valid, bus.out_found, bus.out_rotate, bus.out_imm8);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    do_request(32'h3FC, 0, lat, f, r, i, b_ok, s_ok, h_ok);
    checks++;
    if ({f, r, i} !== {1'b1, 4'd15, 8'hFF} || lat !== 16) begin
      errors++;
      $display("FAIL reset_mid_after: got found=%0b rot=%0d imm=%h lat=%0d, want found=1 rot=15 imm=ff lat=16",
               f, r, i, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic f, b_ok, s_ok, h_ok; logic [3:0] r; logic [7:0] i;
    logic [31:0] pair [2] = '{32'h0003FC00, 32'h80000001};
    logic [3:0]  er   [2] = '{4'd11, 4'd1};
    logic [7:0]  ei   [2] = '{8'hFF, 8'h06};
    for (int n = 0; n < 2; n++) begin
      do_request(pair[n], 0, lat, f, r, i, b_ok, s_ok, h_ok);
      checks++;
      if ({f, r, i} !== {1'b1, er[n], ei[n]} || lat !== int'(er[n]) + 1 || !b_ok) begin
        errors++;
        $display("FAIL b2b_%0d: got found=%0b rot=%0d imm=%h lat=%0d busy_ok=%0b, want found=1 rot=%0d imm=%h lat=%0d busy_ok=1",
                 n, f, r, i, lat, b_ok, er[n], ei[n], int'(er[n]) + 1);
      end
    end
  endtask

  task automatic test_random();
    int lat, elat; logic f, ef, b_ok, s_ok, h_ok; logic [3:0] r, er; logic [7:0] i, ei;
    logic [31:0] v;
    for (int n = 0; n < 50; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = ror32({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
        2:       v = ror32({24'd0, 8'($urandom)}, $urandom_range(0, 31));
        default: v = 32'($urandom_range(0, 1023));
      endcase
      ref_encode(v, ef, er, ei);
      elat = ef ? int'(er) + 1 : 16;
      do_request(v, $urandom_range(0, 3), lat, f, r, i, b_ok, s_ok, h_ok);
      checks++;
      if ({f, r, i} !== {ef, er, ei} || lat !== elat) begin
        errors++;
        $display("FAIL rand_result %h: got found=%0b rot=%0d imm=%h lat=%0d, want found=%0b rot=%0d imm=%h lat=%0d",
                 v, f, r, i, lat, ef, er, ei, elat);
      end
      checks++;
      if (!(b_ok && s_ok && h_ok)) begin
        errors++;
        $display("FAIL rand_handshake %h: got busy_ok=%0b stable_ok=%0b hs_ok=%0b, want 1/1/1", v, b_ok, s_ok, h_ok);
      end
      if (f === 1'b1) begin
        checks++;
        if (ror32({24'd0, i}, 2 * int'(r)) !== v) begin
          errors++;
          $display("FAIL rand_invariant: got %h ror %0d = %h, want %h", i, 2 * int'(r),
                   ror32({24'd0, i}, 2 * int'(r)), v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
